// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : icache_pkg
// Brief   : Shared constants, FSM encodings and address helpers for icache.
// Revision: 1.0 - initial release
// ============================================================================
package icache_pkg;

    // Default geometry: 2^6 lines of one 32-bit word each.
    localparam int DEF_INDEX_BITS = 6;
    localparam int DEF_TAG_BITS   = 30 - DEF_INDEX_BITS;

    // Controller states.
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_REQ  = 2'd1;
    localparam state_t c_ST_WAIT = 2'd2;

    // Line index of a word address: pc[index_bits+1:2], right-aligned.
    function automatic logic [31:0] idx_of(input logic [31:0] pc, input int index_bits);
        return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    // Tag of a word address: pc[31:index_bits+2], right-aligned.
    function automatic logic [31:0] tag_of(input logic [31:0] pc, input int index_bits);
        return pc >> (index_bits + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
// Module  : icache_array
// Brief   : Valid bits, tag RAM and data RAM for the direct-mapped icache.
//           Combinational read port, synchronous write port.
// Revision: 1.0 - initial release
// ============================================================================
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = DEF_TAG_BITS
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_data
);

    localparam int c_LINES = 1 << INDEX_BITS;

    logic [c_LINES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag  [c_LINES];
    logic [31:0]         r_data [c_LINES];

    // Valid bits are the only reset state; a line becomes valid when filled.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage carries no reset; contents are qualified by r_valid.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            r_tag[wr_idx]  <= wr_tag;
            r_data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = r_valid[rd_idx];
    assign rd_tag   = r_tag[rd_idx];
    assign rd_data  = r_data[rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module  : icache
// Brief   : Direct-mapped, one-word-per-line instruction cache between the
//           fetch unit and memctrl. One-cycle hits; misses issue a single
//           4-byte read on memctrl's icache channel and fill the line.
// Revision: 1.0 - initial release
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    input  logic        flush,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_received,
    input  logic        mc_done,
    input  logic [31:0] mc_data
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    state_t              r_state;
    logic                r_discard;
    logic                r_if_valid;
    logic [31:0]         r_if_inst;
    logic                r_mc_req;
    logic [31:0]         r_mc_addr;

    logic [INDEX_BITS-1:0] w_rd_idx;
    logic [TAG_BITS-1:0]   w_pc_tag;
    logic [TAG_BITS-1:0]   w_rd_tag;
    logic [31:0]           w_rd_data;
    logic                  w_rd_valid;
    logic                  w_hit;
    logic                  w_fill_en;
    logic [INDEX_BITS-1:0] w_wr_idx;
    logic [TAG_BITS-1:0]   w_wr_tag;

    // Lookup side uses the live fetch pc; fill side uses the latched miss address,
    // so the fetch unit may move on (after a flush) while the fill is in flight.
    assign w_rd_idx = INDEX_BITS'(idx_of(if_pc, INDEX_BITS));
    assign w_pc_tag = TAG_BITS'(tag_of(if_pc, INDEX_BITS));
    assign w_wr_idx = INDEX_BITS'(idx_of(r_mc_addr, INDEX_BITS));
    assign w_wr_tag = TAG_BITS'(tag_of(r_mc_addr, INDEX_BITS));
    assign w_hit    = w_rd_valid && (w_rd_tag == w_pc_tag);

    // A fill lands whenever memctrl returns data for our outstanding read; the
    // REQ term covers received and done arriving together.
    assign w_fill_en = rdy_in && mc_done &&
                       ((r_state == c_ST_WAIT) || ((r_state == c_ST_REQ) && mc_received));

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rd_idx   (w_rd_idx),
        .rd_tag   (w_rd_tag),
        .rd_data  (w_rd_data),
        .rd_valid (w_rd_valid),
        .wr_en    (w_fill_en),
        .wr_idx   (w_wr_idx),
        .wr_tag   (w_wr_tag),
        .wr_data  (mc_data)
    );

    // Controller FSM and output registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= c_ST_IDLE;
            r_discard  <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_inst  <= 32'd0;
            r_mc_req   <= 1'b0;
            r_mc_addr  <= 32'd0;
        end else if (rdy_in) begin
            r_if_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (if_req && !flush) begin
                        if (w_hit) begin
                            r_if_valid <= 1'b1;
                            r_if_inst  <= w_rd_data;
                        end else begin
                            r_mc_req  <= 1'b1;
                            r_mc_addr <= {if_pc[31:2], 2'b00};
                            r_state   <= c_ST_REQ;
                        end
                    end
                end
                c_ST_REQ: begin
                    if (mc_received) begin
                        // Drop the request on the accept edge so memctrl does not re-serve it.
                        r_mc_req <= 1'b0;
                        if (mc_done) begin
                            if (!flush) begin
                                r_if_valid <= 1'b1;
                                r_if_inst  <= mc_data;
                            end
                            r_discard <= 1'b0;
                            r_state   <= c_ST_IDLE;
                        end else begin
                            // Accepted read cannot be cancelled; a same-cycle flush only discards it.
                            r_discard <= flush;
                            r_state   <= c_ST_WAIT;
                        end
                    end else if (flush) begin
                        r_mc_req <= 1'b0;
                        r_state  <= c_ST_IDLE;
                    end
                end
                c_ST_WAIT: begin
                    if (mc_done) begin
                        if (!r_discard && !flush) begin
                            r_if_valid <= 1'b1;
                            r_if_inst  <= mc_data;
                        end
                        r_discard <= 1'b0;
                        r_state   <= c_ST_IDLE;
                    end else if (flush) begin
                        r_discard <= 1'b1;
                    end
                end
                default: begin
                    r_mc_req <= 1'b0;
                    r_state  <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign if_valid = r_if_valid;
    assign if_inst  = r_if_inst;
    assign mc_req   = r_mc_req;
    assign mc_addr  = r_mc_addr;

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module  : tb_icache
// Brief   : Directed self-checking bench for icache; the bench plays both the
//           fetch unit and memctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic        flush = 1'b0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_received = 1'b0;
    logic        mc_done = 1'b0;
    logic [31:0] mc_data = 32'd0;

    int n_tests = 0;
    int n_fail  = 0;

    icache u_dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .if_req      (if_req),
        .if_pc       (if_pc),
        .flush       (flush),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .mc_req      (mc_req),
        .mc_addr     (mc_addr),
        .mc_received (mc_received),
        .mc_done     (mc_done),
        .mc_data     (mc_data)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic start_fetch(input logic [31:0] pc);
        if_pc  = pc;
        if_req = 1'b1;
        tick();
    endtask

    task automatic mc_accept();
        mc_received = 1'b1;
        tick();
        mc_received = 1'b0;
    endtask

    task automatic mc_complete(input logic [31:0] data);
        mc_data = data;
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_mc_req", {31'd0, mc_req}, 32'd0);
        check("rst_mc_addr", mc_addr, 32'd0);
        rst_in = 1'b0;
        tick();

        // 1 Cold miss at 0x1000
        start_fetch(32'h0000_1000);
        check("t1_mc_req", {31'd0, mc_req}, 32'd1);
        check("t1_mc_addr", mc_addr, 32'h0000_1000);
        check("t1_no_valid", {31'd0, if_valid}, 32'd0);
        tick();
        check("t1_req_hold", {31'd0, mc_req}, 32'd1);
        mc_accept();
        check("t1_req_drop", {31'd0, mc_req}, 32'd0);
        tick();
        check("t1_wait_no_valid", {31'd0, if_valid}, 32'd0);
        mc_complete(32'h0010_0093);
        check("t1_valid", {31'd0, if_valid}, 32'd1);
        check("t1_inst", if_inst, 32'h0010_0093);
        if_req = 1'b0;
        tick();
        check("t1_pulse", {31'd0, if_valid}, 32'd0);

        // 2 Hit on 0x1000
        start_fetch(32'h0000_1000);
        check("t2_valid", {31'd0, if_valid}, 32'd1);
        check("t2_inst", if_inst, 32'h0010_0093);
        check("t2_no_req", {31'd0, mc_req}, 32'd0);
        if_req = 1'b0;
        tick();
        check("t2_pulse", {31'd0, if_valid}, 32'd0);

        // 3 Conflict: 0x1100 shares index 0 with 0x1000
        start_fetch(32'h0000_1100);
        check("t3_miss_req", {31'd0, mc_req}, 32'd1);
        check("t3_miss_addr", mc_addr, 32'h0000_1100);
        mc_accept();
        mc_complete(32'hAAAA_0001);
        check("t3_valid", {31'd0, if_valid}, 32'd1);
        check("t3_inst", if_inst, 32'hAAAA_0001);
        if_req = 1'b0;
        tick();
        start_fetch(32'h0000_1000);
        check("t3_evict_req", {31'd0, mc_req}, 32'd1);
        check("t3_evict_addr", mc_addr, 32'h0000_1000);
        check("t3_evict_no_valid", {31'd0, if_valid}, 32'd0);
        mc_accept();
        mc_complete(32'h0010_0093);
        check("t3_refill_inst", if_inst, 32'h0010_0093);
        if_req = 1'b0;
        tick();

        // 4 Flush in WAIT: fill completes silently, then hits
        start_fetch(32'h0000_2004);
        check("t4_req", {31'd0, mc_req}, 32'd1);
        mc_accept();
        flush  = 1'b1;
        if_req = 1'b0;
        tick();
        flush = 1'b0;
        mc_complete(32'h1234_5678);
        check("t4_suppressed", {31'd0, if_valid}, 32'd0);
        tick();
        start_fetch(32'h0000_2004);
        check("t4_hit_valid", {31'd0, if_valid}, 32'd1);
        check("t4_hit_inst", if_inst, 32'h1234_5678);
        check("t4_hit_no_req", {31'd0, mc_req}, 32'd0);
        if_req = 1'b0;
        tick();

        // 5 Flush in REQ before accept: request withdrawn, no fill
        start_fetch(32'h0000_3008);
        check("t5_req", {31'd0, mc_req}, 32'd1);
        flush  = 1'b1;
        if_req = 1'b0;
        tick();
        flush = 1'b0;
        check("t5_req_drop", {31'd0, mc_req}, 32'd0);
        start_fetch(32'h0000_3008);
        check("t5_remiss", {31'd0, mc_req}, 32'd1);
        check("t5_remiss_no_valid", {31'd0, if_valid}, 32'd0);
        mc_accept();
        mc_complete(32'h0BAD_F00D);
        check("t5_inst", if_inst, 32'h0BAD_F00D);
        if_req = 1'b0;
        tick();

        // 6 rdy_in low freezes a pending request, even with mc_received up
        start_fetch(32'h0000_400C);
        check("t6_req", {31'd0, mc_req}, 32'd1);
        rdy_in      = 1'b0;
        mc_received = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_frozen_req", {31'd0, mc_req}, 32'd1);
            check("t6_frozen_addr", mc_addr, 32'h0000_400C);
        end
        rdy_in = 1'b1;
        tick();
        mc_received = 1'b0;
        check("t6_accept_after_rdy", {31'd0, mc_req}, 32'd0);

        // Async reset mid-WAIT, then a stray mc_done must be ignored
        #1 rst_in = 1'b1;
        #1;
        check("t6_rst_req", {31'd0, mc_req}, 32'd0);
        tick();
        rst_in = 1'b0;
        if_req = 1'b0;
        mc_complete(32'hDEAD_BEEF);
        check("t6_stray_done", {31'd0, if_valid}, 32'd0);
        tick();
        // Valid bits cleared: a previously cached pc misses again
        start_fetch(32'h0000_1000);
        check("t6_cold_again", {31'd0, mc_req}, 32'd1);
        check("t6_cold_addr", mc_addr, 32'h0000_1000);
        // Async reset during REQ drops mc_req without a clock edge
        #1 rst_in = 1'b1;
        #1;
        check("t6_async_req", {31'd0, mc_req}, 32'd0);
        check("t6_async_addr", mc_addr, 32'd0);
        if_req = 1'b0;
        tick();
        rst_in = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
